pedestrian_call: RTL and testbench

PEDESTRIAN_CALL -- requirements
Module: pedestrian_call

---
 rtl/traffic_pkg.sv | 31 +++
 rtl/button_debouncer.sv | 48 ++++
 rtl/pedestrian_call.sv | 111 +++++++++++
 tb/tb_pedestrian_call.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and timing constants for the low-frequency traffic blocks
package traffic_pkg;

  localparam int CLK_LF_HZ = 10000;

  localparam int DEBOUNCE_MS = 20;
  localparam int LOCKOUT_MS  = 2000;
  localparam int BLINK_MS    = 500;

  localparam int DEBOUNCE_CYC_DEFAULT = CLK_LF_HZ * DEBOUNCE_MS / 1000;
  localparam int LOCKOUT_CYC_DEFAULT  = CLK_LF_HZ * LOCKOUT_MS / 1000;
  localparam int BLINK_CYC_DEFAULT    = CLK_LF_HZ * BLINK_MS / 1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVING = 2'd2,
    HOLDOFF = 2'd3
  } ped_state_t;

  // Bits needed to represent values 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizer, level debouncer and rising-edge press pulse
module button_debouncer
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYC);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      // Any sample matching the accepted level restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/pedestrian_call.sv
// rtl/pedestrian_call.sv - pedestrian call request FSM with walk handshake, lockout and wait blink
module pedestrian_call
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
  parameter int LOCKOUT_CYC  = LOCKOUT_CYC_DEFAULT,
  parameter int BLINK_CYC    = BLINK_CYC_DEFAULT
) (
  input  logic CLK,
  input  logic reset,
  input  logic button,
  input  logic walk,
  output logic request,
  output logic green_led,
  output logic red_led,
  output logic wait_led
);

  localparam int LOCK_W  = clog2(LOCKOUT_CYC + 1);
  localparam int BLINK_W = clog2(BLINK_CYC + 1);
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCKOUT_CYC - 1);
  localparam logic [LOCK_W-1:0]  LOCK_MAX   = LOCK_W'(LOCKOUT_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX  = BLINK_W'(BLINK_CYC);

  ped_state_t          state;
  ped_state_t          next_state;
  logic [LOCK_W-1:0]   lock_cnt;
  logic [LOCK_W-1:0]   lock_next;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                press;
  logic                request_next;
  logic                green_next;

  button_debouncer #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_button (
    .clk   (CLK),
    .reset (reset),
    .raw   (button),
    .press (press)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      request   <= 1'b0;
      green_led <= 1'b0;
      red_led   <= 1'b1;
    end else begin
      state     <= next_state;
      lock_cnt  <= lock_next;
      request   <= request_next;
      green_led <= green_next;
      red_led   <= ~green_next;
    end
  end

  // walk wins over a press arriving in the same IDLE cycle.
  always_comb begin
    next_state = state;
    lock_next  = '0;
    case (state)
      IDLE: begin
        if (walk) next_state = SERVING;
        else if (press) next_state = ARMED;
      end
      ARMED: begin
        if (walk) next_state = SERVING;
      end
      SERVING: begin
        if (!walk) next_state = HOLDOFF;
      end
      HOLDOFF: begin
        if (walk) begin
          next_state = SERVING;
        end else if (lock_cnt >= LOCK_LAST) begin
          next_state = IDLE;
        end else begin
          lock_next = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    request_next = (next_state == ARMED);
    green_next   = (next_state == SERVING);
  end

  // Outputs follow next_state so they line up with the state register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wait_led  <= 1'b0;
      blink_cnt <= '0;
    end else if (next_state == ARMED) begin
      if (state != ARMED) begin
        wait_led  <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt >= BLINK_LAST) begin
        wait_led  <= ~wait_led;
        blink_cnt <= '0;
      end else if (blink_cnt != BLINK_MAX) begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      wait_led  <= 1'b0;
      blink_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pedestrian_call.sv
// tb/tb_pedestrian_call.sv - directed scoreboard bench for pedestrian_call
module tb_pedestrian_call;
  import traffic_pkg::*;

  localparam int DEB   = 4;
  localparam int LOCK  = 20;
  localparam int BLINK = 3;

  // {request, green_led, red_led, wait_led}
  localparam logic [3:0] O_IDLE  = 4'b0010;
  localparam logic [3:0] O_ARMON = 4'b1011;
  localparam logic [3:0] O_ARMOF = 4'b1010;
  localparam logic [3:0] O_SERV  = 4'b0100;

  typedef struct {
    string      tag;
    logic [3:0] outs;
    logic       chk_st;
    ped_state_t st;
  } exp_t;

  logic CLK = 1'b0;
  logic reset;
  logic button;
  logic walk;
  logic request;
  logic green_led;
  logic red_led;
  logic wait_led;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pedestrian_call #(
    .DEBOUNCE_CYC(DEB),
    .LOCKOUT_CYC (LOCK),
    .BLINK_CYC   (BLINK)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .button   (button),
    .walk     (walk),
    .request  (request),
    .green_led(green_led),
    .red_led  (red_led),
    .wait_led (wait_led)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Expectation goes in before the edge; it is popped and compared 1 time unit after it.
  task automatic step(input string tag, input logic [3:0] outs, input logic chk_st, input ped_state_t st);
    exp_t e;
    logic [3:0] obs;
    sb.push_back('{tag, outs, chk_st, st});
    @(posedge CLK);
    #1;
    e   = sb.pop_front();
    obs = {request, green_led, red_led, wait_led};
    checks++;
    assert (obs === e.outs) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.outs);
    end
    if (e.chk_st) begin
      checks++;
      assert (dut.state === e.st) else begin
        errors++;
        $error("FAIL %s_state observed=%0d expected=%0d", e.tag, int'(dut.state), int'(e.st));
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    button = 1'b0;
    walk   = 1'b0;
    step("reset", O_IDLE, 1'b1, IDLE);
    step("reset_hold", O_IDLE, 1'b1, IDLE);
    reset = 1'b0;

    // Bounce: two-cycle toggles never satisfy a 4-cycle stable window.
    for (int i = 0; i < 10; i++) begin
      button = ((i / 2) % 2) == 1;
      step("bounce", O_IDLE, 1'b1, IDLE);
    end
    button = 1'b1;
    for (int i = 0; i < 6; i++) step("hold_pre", O_IDLE, 1'b0, IDLE);
    step("press_latency", O_ARMON, 1'b1, ARMED);

    // Blink: entry cycle above was the first 1 of the pattern.
    for (int k = 1; k < 12; k++) begin
      step("blink", (((k / BLINK) % 2) == 0) ? O_ARMON : O_ARMOF, 1'b0, ARMED);
    end

    // Handshake and lockout.
    walk   = 1'b1;
    button = 1'b0;
    step("walk_grant", O_SERV, 1'b1, SERVING);
    for (int i = 1; i < 30; i++) step("serving", O_SERV, 1'b0, SERVING);
    walk = 1'b0;
    for (int k = 0; k < LOCK; k++) begin
      step("holdoff", O_IDLE, 1'b1, HOLDOFF);
      if (k == 0) button = 1'b1;
      if (k == 10) button = 1'b0;
    end
    step("holdoff_exit", O_IDLE, 1'b1, IDLE);
    button = 1'b1;
    for (int i = 0; i < 6; i++) step("reentry_pre", O_IDLE, 1'b0, IDLE);
    step("reentry_press", O_ARMON, 1'b1, ARMED);

    // Reset while ARMED drops the call.
    reset  = 1'b1;
    button = 1'b0;
    step("reset_armed", O_IDLE, 1'b1, IDLE);
    reset = 1'b0;

    // Press pulse and walk rise land in the same IDLE cycle.
    button = 1'b1;
    for (int i = 0; i < 5; i++) step("simul_pre", O_IDLE, 1'b0, IDLE);
    step("simul_pre", O_IDLE, 1'b1, IDLE);
    walk = 1'b1;
    step("simul", O_SERV, 1'b1, SERVING);
    for (int i = 0; i < 4; i++) step("simul_no_req", O_SERV, 1'b0, SERVING);

    // Reset in SERVING with the button still held.
    reset = 1'b1;
    walk  = 1'b0;
    step("reset_serving", O_IDLE, 1'b1, IDLE);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step("held_pre", O_IDLE, 1'b0, IDLE);
    step("held_press", O_ARMON, 1'b1, ARMED);
    step("held_after", O_ARMON, 1'b1, ARMED);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
